delay_timer: RTL and testbench

Programmable, pausable delay timer for the game's sequencing logic (frame pacing, obstacle spawn spacing, crash/restart pauses). Counts enabled clock cycles up to a limit latched at start, then either holds a `done` level (one-shot) or emits a one-cycle `tick` and reloads (periodic). It generalises the fixed 5M-cycle delay into a parametrised timer with a run-time limit, restart/abort control and a periodic mode.

---
 rtl/delay_timer_pkg.sv | 16 +
 rtl/delay_prescaler.sv | 36 +++
 rtl/delay_timer.sv | 118 +++++++++++
 tb/tb_delay_timer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_timer_pkg.sv
// delay_timer_pkg: shared types and defaults for the delay timer.
//   state_t             - controller states (IDLE / RUN / EXPIRED)
//   DELAY_DEFAULT_WIDTH - default counter/limit width
//   DELAY_DEFAULT_LIMIT - legacy fixed delay length, kept for callers
package delay_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    localparam int unsigned DELAY_DEFAULT_WIDTH = 25;
    localparam int unsigned DELAY_DEFAULT_LIMIT = 5_000_000;

endpackage

// File: rtl/delay_prescaler.sv
// delay_prescaler: divides enabled cycles into count steps.
//   clk    - system clock
//   resetn - asynchronous active-low reset
//   clear  - synchronous restart of the prescale phase
//   enable - advance the prescaler this cycle
//   step   - high on the enabled cycle that completes PRESCALE cycles
// Only instantiated when DELAY_TIMER_PRESCALE_EN is defined.
module delay_prescaler #(
    parameter int unsigned PRESCALE = 50
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic step
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt;

    // step is an internal strobe qualified by the caller's enable
    assign step = enable && (cnt == CW'(PRESCALE - 1));

    // Phase counter: wraps after PRESCALE enabled cycles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= step ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/delay_timer.sv
// delay_timer: programmable, pausable one-shot / periodic delay timer.
//   clk      - system clock
//   resetn   - asynchronous active-low reset
//   start    - latch limit and mode, clear count, enter RUN
//   stop     - abort to IDLE (wins over start)
//   enable   - run/pause qualifier
//   periodic - mode latched with start: 1 periodic, 0 one-shot
//   limit    - delay length in count steps (0 treated as 1)
//   done     - one-shot expiry level (tracks enable while expired)
//   tick     - one-cycle expiry pulse
//   busy     - high while in RUN
//   count    - current count
// Optional feature macro: DELAY_TIMER_PRESCALE_EN (PRESCALE-cycle step prescaler).
module delay_timer
    import delay_timer_pkg::*;
#(
    parameter int unsigned WIDTH    = DELAY_DEFAULT_WIDTH,
    parameter int unsigned PRESCALE = 50
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic             enable,
    input  logic             periodic,
    input  logic [WIDTH-1:0] limit,
    output logic             done,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    state_t           state;
    logic [WIDTH-1:0] limit_q;
    logic             mode_q;
    logic             step_c;
    logic             last_c;

    // Final step of the current period
    assign last_c = (count == limit_q - WIDTH'(1));

`ifdef DELAY_TIMER_PRESCALE_EN
    logic pre_en_c;
    logic pre_clear_c;

    assign pre_en_c    = (state == ST_RUN) && enable;
    assign pre_clear_c = start || stop || (pre_en_c && step_c && last_c);

    delay_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .resetn (resetn),
        .clear  (pre_clear_c),
        .enable (pre_en_c),
        .step   (step_c)
    );
`else
    logic unused_prescale;

    assign step_c          = 1'b1;
    assign unused_prescale = ^PRESCALE;
`endif

    // Controller and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            count   <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            done    <= 1'b0;
            tick    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (stop) begin
                state <= ST_IDLE;
                count <= '0;
                done  <= 1'b0;
                busy  <= 1'b0;
            end else if (start) begin
                state   <= ST_RUN;
                limit_q <= (limit == '0) ? WIDTH'(1) : limit;
                mode_q  <= periodic;
                count   <= '0;
                done    <= 1'b0;
                busy    <= 1'b1;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (enable && step_c) begin
                            if (last_c) begin
                                tick <= 1'b1;
                                if (mode_q) begin
                                    count <= '0;
                                end else begin
                                    state <= ST_EXPIRED;
                                    count <= limit_q;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                count <= count + WIDTH'(1);
                            end
                        end
                    end
                    ST_EXPIRED: begin
                        done <= enable;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_delay_timer.sv
// tb_delay_timer: scoreboard bench for delay_timer. A driver applies
// directed and random stimulus, predicts the outputs after each edge from
// a step-counting reference model and queues them; a monitor compares the
// queued prediction against the DUT on every falling edge.
module tb_delay_timer;

    localparam int unsigned W        = 25;
    localparam int unsigned PRESCALE = 4;
`ifdef DELAY_TIMER_PRESCALE_EN
    localparam int unsigned PS = PRESCALE;
`else
    localparam int unsigned PS = 1;
`endif

    typedef struct {
        logic         tick;
        logic         done;
        logic         busy;
        logic [W-1:0] count;
    } exp_t;

    logic         clk;
    logic         resetn;
    logic         start;
    logic         stop;
    logic         enable;
    logic         periodic;
    logic [W-1:0] limit;
    logic         done;
    logic         tick;
    logic         busy;
    logic [W-1:0] count;

    int checks;
    int errors;

    exp_t exp_q[$];

    // Reference model: 0 idle, 1 running, 2 expired
    int m_phase;
    int m_len;
    int m_per;
    int m_cycles;   // enabled run cycles since start / last period
    int m_done;

    delay_timer #(
        .WIDTH    (W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .stop     (stop),
        .enable   (enable),
        .periodic (periodic),
        .limit    (limit),
        .done     (done),
        .tick     (tick),
        .busy     (busy),
        .count    (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_phase  = 0;
        m_len    = 0;
        m_per    = 0;
        m_cycles = 0;
        m_done   = 0;
    endtask

    // Advance the model by one edge using the inputs sampled at that edge
    function automatic exp_t model_edge();
        exp_t e;
        e.tick = 1'b0;
        if (stop) begin
            m_phase  = 0;
            m_cycles = 0;
            m_done   = 0;
        end else if (start) begin
            m_phase  = 1;
            m_len    = (limit == '0) ? 1 : int'(limit);
            m_per    = int'(periodic);
            m_cycles = 0;
            m_done   = 0;
        end else if (m_phase == 1 && enable) begin
            m_cycles++;
            if (m_cycles == m_len * PS) begin
                e.tick = 1'b1;
                if (m_per != 0) begin
                    m_cycles = 0;
                end else begin
                    m_phase = 2;
                    m_done  = 1;
                end
            end
        end else if (m_phase == 2) begin
            m_done = int'(enable);
        end
        e.done  = (m_done != 0);
        e.busy  = (m_phase == 1);
        case (m_phase)
            1:       e.count = W'((m_cycles / PS) % m_len);
            2:       e.count = W'(m_len);
            default: e.count = '0;
        endcase
        return e;
    endfunction

    // One clock: hold inputs over the edge, queue the prediction
    task automatic drive(input logic st, input logic sp, input logic en,
                         input logic per, input int lim);
        start    = st;
        stop     = sp;
        enable   = en;
        periodic = per;
        limit    = W'(lim);
        @(posedge clk);
        exp_q.push_back(model_edge());
        #1;
    endtask

    task automatic run(input int n, input logic en);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, en, 1'($urandom_range(1)), int'($urandom_range(9)));
    endtask

    // Monitor: compare each queued prediction on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (tick !== e.tick || done !== e.done || busy !== e.busy || count !== e.count) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got tick=%b done=%b busy=%b count=%0d, expected tick=%b done=%b busy=%b count=%0d",
                             $time, tick, done, busy, count, e.tick, e.done, e.busy, e.count);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        resetn   = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        enable   = 1'b0;
        periodic = 1'b0;
        limit    = '0;
        #12;
        checks++;
        if (done !== 1'b0 || tick !== 1'b0 || busy !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL reset_state: got done=%b tick=%b busy=%b count=%0d, expected all 0",
                     done, tick, busy, count);
        end
        @(negedge clk);
        resetn = 1'b1;
        run(2, 1'b1);

        // One-shot L=4, then done follows enable in EXPIRED
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4);
        run(6, 1'b1);
        run(2, 1'b0);
        run(2, 1'b1);

        // Periodic L=3, while limit/periodic inputs wander
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3);
        run(10, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0);

        // One-shot L=5 with a 3-cycle pause
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5);
        run(2, 1'b1);
        run(3, 1'b0);
        run(6 * PS, 1'b1);

        // start+stop together while running: stop wins
        drive(1'b1, 1'b0, 1'b1, 1'b0, 6);
        run(2, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 6);
        run(3, 1'b1);

        // limit 0 behaves as 1
        drive(1'b1, 1'b0, 1'b1, 1'b0, 0);
        run(3 * PS, 1'b1);

        // Prescale scenario L=3
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3);
        run(14, 1'b1);

        // Restart from EXPIRED
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2);
        run(5, 1'b1);

        // Asynchronous reset mid-count at count 7
        drive(1'b1, 1'b0, 1'b1, 1'b0, 20);
        run(7 * PS, 1'b1);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0 || tick !== 1'b0 || busy !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL async_reset: got done=%b tick=%b busy=%b count=%0d, expected all 0",
                     done, tick, busy, count);
        end
        model_reset();
        @(posedge clk);
        exp_q.push_back(model_edge());
        #1;
        resetn = 1'b1;
        run(4, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic st;
            logic sp;
            st = ($urandom_range(11) == 0);
            sp = ($urandom_range(24) == 0);
            drive(st, sp, ($urandom_range(4) != 0), 1'($urandom_range(1)),
                  int'($urandom_range(6)));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
